// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types.
// Used by the round-key mixer and the key paths.
package aes_pkg;

    localparam int AES_NB    = 16;
    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    typedef logic [AES_NB-1:0][7:0] state_t;

    function automatic int rnd_idx_w(input int nr);
        return $clog2(nr + 1);
    endfunction

endpackage

// File: rtl/round_key_fifo.sv
// Small synchronous FIFO for prefetched round keys.
// Read data is first-word fall-through.
module round_key_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 128,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    // A push into a full FIFO is only legal alongside a pop.
    assign w_push  = i_push && (!o_full || i_pop);
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rp];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

endmodule

// File: rtl/enc_round_key_mixer.sv
// Handshaked AddRoundKey stage with round counting
// and a local round-key prefetch FIFO.
module enc_round_key_mixer
    import aes_pkg::*;
#(
    parameter int NB         = AES_NB,
    parameter int NUM_ROUNDS = AES256_NR,
    parameter int KEY_DEPTH  = 2,
    parameter int RW         = rnd_idx_w(AES256_NR)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            dec_mode,
    output logic            busy,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [NB*8-1:0] s_data,
    output logic            key_req,
    output logic [RW-1:0]   key_idx,
    input  logic            key_ack,
    input  logic [NB*8-1:0] key_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [NB*8-1:0] m_data,
    output logic [RW-1:0]   m_round,
    output logic            m_last
);

    localparam int DW = NB * 8;
    localparam int CW = $clog2(KEY_DEPTH) + 1;
    localparam logic [RW:0]   NKEYS = (RW+1)'(NUM_ROUNDS + 1);
    localparam logic [RW-1:0] LAST  = RW'(NUM_ROUNDS);
    localparam logic [CW-1:0] FULL  = CW'(KEY_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} ctrl_e;

    ctrl_e         r_state, w_state_nxt;
    logic          r_dec, w_dec_nxt;
    logic [RW-1:0] r_idx, w_idx_nxt;
    logic [RW:0]   r_fetched, w_fetched_nxt;
    logic [RW-1:0] r_cnt, w_cnt_nxt;
    logic          r_key_req, w_key_req_nxt;
    logic          r_m_valid;
    logic          r_m_last;
    logic [DW-1:0] r_m_data;
    logic [RW-1:0] r_m_round;

    logic          w_push;
    logic          w_accept;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_occ;
    logic [CW-1:0] w_occ_nxt;
    logic [DW-1:0] w_key;

    assign w_push    = r_key_req && key_ack && (!w_full || w_accept);
    assign s_ready   = (r_state == RUN) && !w_empty
                       && (!r_m_valid || m_ready);
    assign w_accept  = s_valid && s_ready;
    assign w_occ_nxt = w_occ + CW'(w_push) - CW'(w_accept);

    round_key_fifo #(
        .DEPTH (KEY_DEPTH),
        .W     (DW)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (key_data),
        .i_pop   (w_accept),
        .o_data  (w_key),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_dec_nxt     = r_dec;
        w_idx_nxt     = r_idx;
        w_fetched_nxt = r_fetched + (RW+1)'(w_push);
        w_cnt_nxt     = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = RUN;
                    w_dec_nxt     = dec_mode;
                    w_idx_nxt     = dec_mode ? LAST : '0;
                    w_fetched_nxt = '0;
                    w_cnt_nxt     = '0;
                end
            end
            RUN: begin
                // The index parks on its final value instead of wrapping.
                if (w_push && (w_fetched_nxt < NKEYS))
                    w_idx_nxt = r_dec ? r_idx - 1'b1 : r_idx + 1'b1;
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == LAST) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_m_valid && m_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_key_req_nxt = (w_state_nxt == RUN)
                        && (w_fetched_nxt < NKEYS)
                        && (w_occ_nxt < FULL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_dec     <= 1'b0;
            r_idx     <= '0;
            r_fetched <= '0;
            r_cnt     <= '0;
            r_key_req <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dec     <= w_dec_nxt;
            r_idx     <= w_idx_nxt;
            r_fetched <= w_fetched_nxt;
            r_cnt     <= w_cnt_nxt;
            r_key_req <= w_key_req_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_round <= '0;
            r_m_last  <= 1'b0;
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= s_data ^ w_key;
            r_m_round <= r_dec ? LAST - r_cnt : r_cnt;
            r_m_last  <= (r_cnt == LAST);
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign busy    = (r_state != IDLE);
    assign key_req = r_key_req;
    assign key_idx = r_idx;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_round = r_m_round;
    assign m_last  = r_m_last;

endmodule

// File: tb/tb_enc_round_key_mixer.sv
// Directed self-checking bench for enc_round_key_mixer
// (AES-256 defaults: 16 bytes, rounds 0..14, 2-deep key FIFO).
module tb_enc_round_key_mixer;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         dec_mode;
    logic         busy;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         key_req;
    logic [3:0]   key_idx;
    logic         key_ack;
    logic [127:0] key_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic [3:0]   m_round;
    logic         m_last;

    logic ack_en;
    logic k0mode;
    int   checks = 0;
    int   errors = 0;

    // Block-run observations
    int           n_out, n_push, cyc_first, cyc_last;
    logic [3:0]   o_round [15];
    logic [3:0]   p_idx [15];
    logic [127:0] o_data [15];
    logic         o_last [15];
    logic         busy_pre, busy_post;
    logic         st_held_ok, st_sready_seen, st_keyreq_end, st_valid;

    always #5 clk = ~clk;

    // Key ROM: answers in the same cycle while enabled
    assign key_ack  = key_req && ack_en;
    assign key_data = (k0mode && (key_idx == 4'd0)) ? K0
                      : {16{4'h0, key_idx}};

    enc_round_key_mixer dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .dec_mode (dec_mode),
        .busy     (busy),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .key_req  (key_req),
        .key_idx  (key_idx),
        .key_ack  (key_ack),
        .key_data (key_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_round  (m_round),
        .m_last   (m_last)
    );

    function automatic logic [127:0] sval(input int j);
        logic [7:0] b;
        b = 8'(8'h30 + j);
        return {16{b}};
    endfunction

    function automatic logic [127:0] kval(input int r);
        logic [7:0] b;
        b = 8'(r);
        return {16{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        ack_en  = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic run_block(input logic dec, input int stall_after,
                             input int stall_len);
        int nacc = 0;
        int cyc = 0;
        int stall_rem = 0;
        int si = 0;
        bit done = 0;
        logic [127:0] hd;
        logic [3:0] hr;
        n_out = 0; n_push = 0;
        st_held_ok = 1; st_sready_seen = 0; st_keyreq_end = 1;
        st_valid = 0; busy_pre = 0; busy_post = 1;
        cyc_first = 0; cyc_last = 0;
        dec_mode = dec;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && cyc < 300) begin
            m_ready = (stall_rem == 0);
            s_valid = (nacc < 15);
            s_data  = sval(nacc);
            #1;
            if (stall_rem > 0) begin
                if (si == 0) begin
                    hd = m_data; hr = m_round; st_valid = m_valid;
                end else if (m_data !== hd || m_round !== hr
                             || m_valid !== 1'b1) begin
                    st_held_ok = 0;
                end
                if (s_ready) st_sready_seen = 1;
                if (stall_rem == 1) st_keyreq_end = key_req;
                si++;
                stall_rem--;
            end
            if (key_req && key_ack) begin
                if (n_push < 15) p_idx[n_push] = key_idx;
                n_push++;
            end
            if (s_valid && s_ready) nacc++;
            if (m_valid && m_ready && n_out < 15) begin
                o_round[n_out] = m_round;
                o_data[n_out]  = m_data;
                o_last[n_out]  = m_last;
                if (n_out == 0) cyc_first = cyc;
                cyc_last = cyc;
                n_out++;
                if (n_out == stall_after && stall_len > 0)
                    stall_rem = stall_len;
                if (n_out == 15) begin
                    busy_pre = busy;
                    done = 1;
                end
            end
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        busy_post = busy;
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({busy, s_ready, key_req, m_valid, m_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, s_ready, key_req, m_valid, m_last});
        end
        checks++;
        if ({key_idx, m_round} !== 8'h00) begin
            errors++;
            $display("FAIL reset_idx: got %h expected 00", {key_idx, m_round});
        end
        checks++;
        if (m_data !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", m_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_round0();
        k0mode = 1'b1;
        dec_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, key_req, key_idx, s_ready} !== 7'b11_0000_0) begin
            errors++;
            $display("FAIL r0_start: got %b expected 1100000",
                     {busy, key_req, key_idx, s_ready});
        end
        s_valid = 1'b1;
        s_data = 128'h00112233445566778899aabbccddeeff;
        tick();
        checks++;
        if ({s_ready, m_valid} !== 2'b10) begin
            errors++;
            $display("FAIL r0_ready: got %b expected 10", {s_ready, m_valid});
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_round !== 4'd0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL r0_out: got v=%b r=%0d l=%b expected v=1 r=0 l=0",
                     m_valid, m_round, m_last);
        end
        checks++;
        if (m_data !== 128'h00102030405060708090a0b0c0d0e0f0) begin
            errors++;
            $display("FAIL r0_data: got %h expected %h", m_data,
                     128'h00102030405060708090a0b0c0d0e0f0);
        end
        k0mode = 1'b0;
        do_reset();
    endtask

    task automatic test_encrypt_block();
        run_block(1'b0, 0, 0);
        checks++;
        if (n_out != 15 || n_push != 15) begin
            errors++;
            $display("FAIL enc_count: got out=%0d push=%0d expected 15 15",
                     n_out, n_push);
        end
        for (int j = 0; j < 15; j++) begin
            checks++;
            if (p_idx[j] !== 4'(j) || o_round[j] !== 4'(j)
                || o_last[j] !== (j == 14)) begin
                errors++;
                $display("FAIL enc_round[%0d]: got idx=%0d r=%0d l=%b",
                         j, p_idx[j], o_round[j], o_last[j]);
            end
            checks++;
            if (o_data[j] !== (sval(j) ^ kval(j))) begin
                errors++;
                $display("FAIL enc_data[%0d]: got %h expected %h",
                         j, o_data[j], sval(j) ^ kval(j));
            end
        end
        checks++;
        if (cyc_last - cyc_first != 14) begin
            errors++;
            $display("FAIL enc_rate: got span %0d expected 14",
                     cyc_last - cyc_first);
        end
        checks++;
        if (busy_pre !== 1'b1 || busy_post !== 1'b0) begin
            errors++;
            $display("FAIL enc_busy: got pre=%b post=%b expected 1 0",
                     busy_pre, busy_post);
        end
    endtask

    task automatic test_decrypt();
        run_block(1'b1, 0, 0);
        checks++;
        if (n_out != 15 || n_push != 15 || busy_post !== 1'b0) begin
            errors++;
            $display("FAIL dec_count: got out=%0d push=%0d busy=%b",
                     n_out, n_push, busy_post);
        end
        for (int j = 0; j < 15; j++) begin
            checks++;
            if (p_idx[j] !== 4'(14 - j) || o_round[j] !== 4'(14 - j)
                || o_last[j] !== (j == 14)) begin
                errors++;
                $display("FAIL dec_round[%0d]: got idx=%0d r=%0d l=%b",
                         j, p_idx[j], o_round[j], o_last[j]);
            end
            checks++;
            if (o_data[j] !== (sval(j) ^ kval(14 - j))) begin
                errors++;
                $display("FAIL dec_data[%0d]: got %h expected %h",
                         j, o_data[j], sval(j) ^ kval(14 - j));
            end
        end
    endtask

    task automatic test_backpressure();
        run_block(1'b0, 3, 5);
        checks++;
        if (st_valid !== 1'b1 || st_held_ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got valid=%b held=%b expected 1 1",
                     st_valid, st_held_ok);
        end
        checks++;
        if (st_sready_seen !== 1'b0) begin
            errors++;
            $display("FAIL bp_sready: got 1 expected 0");
        end
        checks++;
        if (st_keyreq_end !== 1'b0) begin
            errors++;
            $display("FAIL bp_keyreq: got %b expected 0", st_keyreq_end);
        end
        checks++;
        if (n_out != 15) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 15", n_out);
        end
        for (int j = 0; j < 15; j++) begin
            checks++;
            if (o_round[j] !== 4'(j) || o_data[j] !== (sval(j) ^ kval(j))) begin
                errors++;
                $display("FAIL bp_out[%0d]: got r=%0d d=%h expected r=%0d d=%h",
                         j, o_round[j], o_data[j], j, sval(j) ^ kval(j));
            end
        end
    endtask

    task automatic test_key_starvation();
        k0mode = 1'b1;
        ack_en = 1'b0;
        dec_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        s_data = sval(0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({s_ready, key_req, key_idx, m_valid} !== 7'b0_1_0000_0) begin
                errors++;
                $display("FAIL starve_wait[%0d]: got %b expected 0100000",
                         i, {s_ready, key_req, key_idx, m_valid});
            end
            tick();
        end
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL starve_push: got s_ready=%b expected 1", s_ready);
        end
        tick();
        s_data = sval(1);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_round !== 4'd0 || m_data !== (sval(0) ^ K0)) begin
            errors++;
            $display("FAIL starve_out0: got v=%b r=%0d d=%h expected d=%h",
                     m_valid, m_round, m_data, sval(0) ^ K0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({m_valid, s_ready} !== 2'b00) begin
                errors++;
                $display("FAIL starve_idle[%0d]: got %b expected 00",
                         i, {m_valid, s_ready});
            end
        end
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_round !== 4'd1
            || m_data !== (sval(1) ^ kval(1))) begin
            errors++;
            $display("FAIL starve_out1: got v=%b r=%0d d=%h expected d=%h",
                     m_valid, m_round, m_data, sval(1) ^ kval(1));
        end
        k0mode = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_midblock();
        int nacc = 0;
        dec_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50 && nacc < 8; c++) begin
            s_valid = 1'b1;
            s_data = sval(nacc);
            #1;
            if (s_ready) nacc++;
            tick();
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({busy, s_ready, key_req, m_valid, m_last, key_idx, m_round}
            !== 13'b0) begin
            errors++;
            $display("FAIL midrst_flags: got %b expected 0",
                     {busy, s_ready, key_req, m_valid, m_last, key_idx, m_round});
        end
        checks++;
        if (m_data !== 128'h0) begin
            errors++;
            $display("FAIL midrst_data: got %h expected 0", m_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        start = 1'b1;
        s_data = sval(0);
        tick();
        start = 1'b0;
        checks++;
        if ({busy, key_req, key_idx, s_ready} !== 7'b11_0000_0) begin
            errors++;
            $display("FAIL midrst_restart: got %b expected 1100000",
                     {busy, key_req, key_idx, s_ready});
        end
        tick();
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_round !== 4'd0 || m_data !== sval(0)) begin
            errors++;
            $display("FAIL midrst_first: got v=%b r=%0d d=%h expected d=%h",
                     m_valid, m_round, m_data, sval(0));
        end
        do_reset();
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        dec_mode = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b1;
        ack_en   = 1'b1;
        k0mode   = 1'b0;
        test_reset();
        test_round0();
        test_encrypt_block();
        test_decrypt();
        test_backpressure();
        test_key_starvation();
        test_reset_midblock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
